// File: rtl/mrx_sync_ctrl.sv
// mrx_sync_ctrl: measures the front-panel sync/tx sequence and opens
// a locked capture window that forwards CAPTURE_N RX samples.
module mrx_sync_ctrl #(
   parameter int DATA_WIDTH     = 16,
   parameter int CNT_WIDTH      = 24,
   parameter int SYNC_SIG_N     = 8400,
   parameter int SYNC_TOL       = 64,
   parameter int CAPTURE_N      = 40960,
   parameter int GPIO_REG_WIDTH = 12,
   parameter int SYNC_IN_BIT    = 2,
   parameter int TX_IN_BIT      = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
   output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr,
   input  logic [DATA_WIDTH-1:0]     irx,
   input  logic [DATA_WIDTH-1:0]     qrx,
   input  logic                      rx_in_valid,
   output logic [2*DATA_WIDTH-1:0]   out_tdata,
   output logic                      out_tvalid,
   input  logic                      out_tready,
   output logic                      out_tlast,
   output logic                      locked,
   output logic                      sync_err,
   output logic                      overflow,
   output logic [2:0]                state,
   output logic [CNT_WIDTH-1:0]      cnt
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SYNC_A  = 3'd1,
      SYNC_B  = 3'd2,
      GUARD   = 3'd3,
      CAPTURE = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] TOL_LO =
      CNT_WIDTH'(SYNC_SIG_N - SYNC_TOL);
   localparam logic [CNT_WIDTH-1:0] TOL_HI =
      CNT_WIDTH'(SYNC_SIG_N + SYNC_TOL);
   localparam logic [CNT_WIDTH-1:0] NOM =
      CNT_WIDTH'(SYNC_SIG_N);
   localparam logic [CNT_WIDTH-1:0] CAP_LAST =
      CNT_WIDTH'(CAPTURE_N - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   // synchronizer and edge-detect state
   logic       sync_meta_q;
   logic       sync_s_q;
   logic       sync_p_q;
   logic       tx_meta_q;
   logic       tx_s_q;
   logic       tx_p_q;
   logic [1:0] fill_q;
   logic       armed_q;

   logic sync_rise;
   logic sync_fall;
   logic tx_rise;
   logic tx_fall;

   // control state
   state_t               state_q;
   state_t               state_d;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic                 err_q;
   logic                 err_d;
   logic                 enter;

   // capture datapath state
   logic [CNT_WIDTH-1:0]    smp_q;
   logic [CNT_WIDTH-1:0]    smp_d;
   logic [2*DATA_WIDTH-1:0] tdata_q;
   logic                    tvalid_q;
   logic                    tlast_q;
   logic                    ovf_q;

   logic consume;
   logic last_smp;
   logic load;
   logic drop;
   logic cap_entry;

   // only two front-panel pins are observed
   logic gpio_unused;
   assign gpio_unused = ^fp_gpio_in;

   // two-flop synchronizers plus one delay stage for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta_q <= 1'b0;
         sync_s_q    <= 1'b0;
         sync_p_q    <= 1'b0;
         tx_meta_q   <= 1'b0;
         tx_s_q      <= 1'b0;
         tx_p_q      <= 1'b0;
         fill_q      <= 2'b00;
         armed_q     <= 1'b0;
      end else begin
         sync_meta_q <= fp_gpio_in[SYNC_IN_BIT];
         sync_s_q    <= sync_meta_q;
         sync_p_q    <= sync_s_q;
         tx_meta_q   <= fp_gpio_in[TX_IN_BIT];
         tx_s_q      <= tx_meta_q;
         tx_p_q      <= tx_s_q;
         fill_q      <= {fill_q[0], 1'b1};
         // a sync line already high out of reset must go low first
         armed_q     <= armed_q | (fill_q[1] & ~sync_s_q);
      end
   end

   assign sync_rise = sync_s_q & ~sync_p_q & armed_q;
   assign sync_fall = ~sync_s_q & sync_p_q;
   assign tx_rise   = tx_s_q & ~tx_p_q;
   assign tx_fall   = ~tx_s_q & tx_p_q;

   // state register, segment counter and error pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // next-state logic; tolerance checks see cnt before increment
   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sync_rise) begin
               state_d = SYNC_A;
            end
         end
         SYNC_A: begin
            if (sync_fall || cnt_q > TOL_HI) begin
               err_d = 1'b1;
            end else if (tx_fall) begin
               if (cnt_q >= TOL_LO) begin
                  state_d = SYNC_B;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         SYNC_B: begin
            if (cnt_q > TOL_HI) begin
               err_d = 1'b1;
            end else if (sync_fall) begin
               if (cnt_q >= TOL_LO) begin
                  state_d = GUARD;
               end else begin
                  err_d = 1'b1;
               end
            end else if (tx_rise) begin
               err_d = 1'b1;
            end
         end
         GUARD: begin
            if (sync_rise) begin
               err_d   = 1'b1;
               state_d = SYNC_A;
            end else if (tx_fall) begin
               err_d = 1'b1;
            end else if (cnt_q == NOM) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (sync_rise) begin
               err_d   = 1'b1;
               state_d = SYNC_A;
            end else if (consume && last_smp) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // every error returns to IDLE except a fresh sync rise
      if (err_d && !sync_rise) begin
         state_d = IDLE;
      end
   end

   // segment counter restarts at 1 on any state entry, saturates
   always_comb begin
      enter = (state_d != state_q);
      cnt_d = cnt_q;
      if (enter) begin
         cnt_d = CNT_WIDTH'(1);
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   // sample accounting: drops still count toward the window
   always_comb begin
      consume   = (state_q == CAPTURE) & rx_in_valid & ~sync_rise;
      last_smp  = (smp_q == CAP_LAST);
      load      = consume & (~tvalid_q | out_tready);
      drop      = consume & tvalid_q & ~out_tready;
      cap_entry = (state_q == GUARD) & (state_d == CAPTURE);
      smp_d     = smp_q;
      if (cap_entry) begin
         smp_d = '0;
      end else if (consume && smp_q != CNT_MAX) begin
         smp_d = smp_q + CNT_WIDTH'(1);
      end
   end

   // single-entry output register with sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         smp_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         smp_q <= smp_d;
         if (load) begin
            tdata_q  <= {qrx, irx};
            tvalid_q <= 1'b1;
            tlast_q  <= last_smp;
         end else if (drop && last_smp) begin
            // final sample lost: mark the beat still waiting
            tlast_q <= 1'b1;
         end else if (out_tready) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
         end
         if (cap_entry) begin
            ovf_q <= 1'b0;
         end else if (drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // output decode
   always_comb begin
      fp_gpio_ddr = '0;
      locked      = (state_q == CAPTURE);
      state       = state_q;
      cnt         = cnt_q;
      sync_err    = err_q;
      out_tdata   = tdata_q;
      out_tvalid  = tvalid_q;
      out_tlast   = tlast_q;
      overflow    = ovf_q;
   end

endmodule
